// File: rtl/uart_bus_bridge_if.sv
// SoC bus seen by the UART debug bridge: one single-beat transfer at a time,
// completed by the device's done strobe.
interface uart_bus_bridge_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic        done;

  modport master (
    output addr, wdata, wmask, wen, ren,
    input  rdata, done
  );

  modport slave (
    input  addr, wdata, wmask, wen, ren,
    output rdata, done
  );
endinterface

// File: rtl/uart_bus_bridge.sv
// UART-driven bus initiator: decodes W/R/H/G command frames from an 8N1 line,
// runs one bus transfer per frame and answers with ACK/NAK or read data.
module uart_bus_bridge #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int BUS_TIMEOUT = 255,
  parameter int GAP_TIMEOUT = (CLK_HZ / BAUD) * 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              uart_tx,
  output logic              cpu_hold,
  uart_bus_bridge_if.master bus
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int BW  = $clog2(CPB + 1);
  localparam int GW  = $clog2(GAP_TIMEOUT + 1);
  localparam int TW  = $clog2(BUS_TIMEOUT + 1);
  localparam logic [BW-1:0] CPB_LAST  = BW'(CPB - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CPB / 2 - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TIMEOUT - 1);
  localparam logic [TW-1:0] BUS_LAST  = TW'(BUS_TIMEOUT - 1);
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_REPLY} state_e;

  // ---------------- receiver ----------------
  logic            rx_sync1_q, rx_sync2_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [BW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid_q, rx_valid_d;

  // Receiver next state: start bit re-checked at half a bit, data at bit centres
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        rx_bit_d = 3'd0;
        if (rx_prev_q && !rx_sync2_q) begin
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + BW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CPB_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          rx_state_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + BW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CPB_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_valid_d = rx_sync2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + BW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver registers and input synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      rx_sync1_q <= uart_rx;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // ---------------- transmitter ----------------
  logic [9:0]    tx_shift_q, tx_shift_d;
  logic [3:0]    tx_bits_q, tx_bits_d;
  logic [BW-1:0] tx_cnt_q, tx_cnt_d;
  logic          uart_tx_q, uart_tx_d;
  logic          tx_load_s;
  logic [7:0]    tx_byte_s;
  logic          tx_idle_s;

  assign tx_idle_s = (tx_bits_q == 4'd0);

  // Transmitter: shifts {stop, data, start} out LSB first, CPB cycles per bit
  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_bits_d  = tx_bits_q;
    tx_cnt_d   = tx_cnt_q;
    uart_tx_d  = 1'b1;
    if (tx_idle_s) begin
      if (tx_load_s) begin
        tx_shift_d = {1'b1, tx_byte_s, 1'b0};
        tx_bits_d  = 4'd10;
        tx_cnt_d   = '0;
      end else begin
        tx_cnt_d = '0;
      end
    end else begin
      uart_tx_d = tx_shift_q[0];
      if (tx_cnt_q == CPB_LAST) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        tx_bits_d  = tx_bits_q - 4'd1;
      end else begin
        tx_cnt_d = tx_cnt_q + BW'(1);
      end
    end
  end

  // Transmitter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift_q <= 10'h3FF;
      tx_bits_q  <= 4'd0;
      tx_cnt_q   <= '0;
      uart_tx_q  <= 1'b1;
    end else begin
      tx_shift_q <= tx_shift_d;
      tx_bits_q  <= tx_bits_d;
      tx_cnt_q   <= tx_cnt_d;
      uart_tx_q  <= uart_tx_d;
    end
  end

  // ---------------- command FSM ----------------
  state_e        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [TW-1:0] bus_cnt_q, bus_cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;
  logic          wen_q, wen_d;
  logic          ren_q, ren_d;
  logic [31:0]   reply_q, reply_d;
  logic [2:0]    reply_left_q, reply_left_d;
  logic          cpu_hold_q, cpu_hold_d;

  // Frame decode, bus handshake with timeout, and reply sequencing
  always_comb begin
    state_d      = state_q;
    is_wr_d      = is_wr_q;
    byte_cnt_d   = byte_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    bus_cnt_d    = bus_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    wen_d        = wen_q;
    ren_d        = ren_q;
    reply_d      = reply_q;
    reply_left_d = reply_left_q;
    cpu_hold_d   = cpu_hold_q;
    tx_load_s    = 1'b0;
    tx_byte_s    = reply_q[7:0];
    case (state_q)
      S_IDLE: begin
        byte_cnt_d = 2'd0;
        gap_cnt_d  = '0;
        if (rx_valid_q) begin
          case (rx_shift_q)
            8'h57: begin is_wr_d = 1'b1; state_d = S_ADDR; end
            8'h52: begin is_wr_d = 1'b0; state_d = S_ADDR; end
            8'h48, 8'h47: begin
              cpu_hold_d   = (rx_shift_q == 8'h48);
              reply_d      = {24'h000000, ACK};
              reply_left_d = 3'd1;
              state_d      = S_REPLY;
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR, S_DATA: begin
        if (rx_valid_q) begin
          gap_cnt_d  = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (state_q == S_ADDR) begin
            addr_d = {rx_shift_q, addr_q[31:8]};
          end else begin
            wdata_d = {rx_shift_q, wdata_q[31:8]};
          end
          if (byte_cnt_q == 2'd3) begin
            bus_cnt_d = '0;
            if (state_q == S_ADDR && is_wr_q) begin
              state_d = S_DATA;
            end else begin
              state_d = S_BUS;
              wen_d   = is_wr_q;
              ren_d   = !is_wr_q;
              wmask_d = is_wr_q ? 4'hF : 4'h0;
            end
          end else begin
            state_d = state_q;
          end
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      S_BUS: begin
        // done in the final timeout cycle still wins over the NAK
        if (bus.done) begin
          wen_d        = 1'b0;
          ren_d        = 1'b0;
          wmask_d      = 4'h0;
          reply_d      = is_wr_q ? {24'h000000, ACK} : bus.rdata;
          reply_left_d = is_wr_q ? 3'd1 : 3'd4;
          state_d      = S_REPLY;
        end else if (bus_cnt_q == BUS_LAST) begin
          wen_d        = 1'b0;
          ren_d        = 1'b0;
          wmask_d      = 4'h0;
          reply_d      = {24'h000000, NAK};
          reply_left_d = 3'd1;
          state_d      = S_REPLY;
        end else begin
          bus_cnt_d = bus_cnt_q + TW'(1);
        end
      end
      S_REPLY: begin
        if (reply_left_q == 3'd0) begin
          state_d = S_IDLE;
        end else if (tx_idle_s) begin
          tx_load_s    = 1'b1;
          reply_d      = {8'h00, reply_q[31:8]};
          reply_left_d = reply_left_q - 3'd1;
        end else begin
          state_d = S_REPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command FSM registers and registered bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      is_wr_q      <= 1'b0;
      byte_cnt_q   <= 2'd0;
      gap_cnt_q    <= '0;
      bus_cnt_q    <= '0;
      addr_q       <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      wmask_q      <= 4'h0;
      wen_q        <= 1'b0;
      ren_q        <= 1'b0;
      reply_q      <= 32'h0000_0000;
      reply_left_q <= 3'd0;
      cpu_hold_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_wr_q      <= is_wr_d;
      byte_cnt_q   <= byte_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      bus_cnt_q    <= bus_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      wen_q        <= wen_d;
      ren_q        <= ren_d;
      reply_q      <= reply_d;
      reply_left_q <= reply_left_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

  assign uart_tx   = uart_tx_q;
  assign cpu_hold  = cpu_hold_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.wmask = wmask_q;
  assign bus.wen   = wen_q;
  assign bus.ren   = ren_q;
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: UART frames in, scoreboarded bus requests and
// TX reply bytes out, against a bus model with a registered one-cycle done.
`timescale 1ns/1ps
module tb_uart_bus_bridge;
  localparam int CLK_HZ      = 1_000_000;
  localparam int BAUD        = 100_000;
  localparam int CPB         = 10;
  localparam int BUS_TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx;
  logic cpu_hold;

  uart_bus_bridge_if bus_if ();

  uart_bus_bridge #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .BUS_TIMEOUT(BUS_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .cpu_hold(cpu_hold), .bus(bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          len;     // request high cycles, 0 = not checked
  } bus_exp_t;

  bus_exp_t   exp_bus[$];
  logic [7:0] exp_tx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // bus device model
  logic        done_en = 1'b1;
  logic [31:0] mem [0:255];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = 8'h00;
  logic [31:0] pre_val = 32'h0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    if (rst) begin
      bus_if.done <= 1'b0;
    end else if (done_en && (bus_if.wen || bus_if.ren) && !bus_if.done) begin
      bus_if.done  <= 1'b1;
      bus_if.rdata <= mem[bus_if.addr[9:2]];
      if (bus_if.wen) mem[bus_if.addr[9:2]] <= bus_if.wdata;
    end else begin
      bus_if.done <= 1'b0;
    end
  end

  // bus request monitor
  initial begin : bus_mon
    bit       active;
    int       len;
    bus_exp_t e;
    active = 1'b0;
    len    = 0;
    e      = '{wr: 1'b0, addr: 32'h0, wdata: 32'h0, wmask: 4'h0, len: 0};
    forever begin
      @(negedge clk);
      if ((bus_if.wen || bus_if.ren) && !active) begin
        active = 1'b1;
        len    = 1;
        if (exp_bus.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_bus_req: got wen=%b ren=%b addr=%h, expected none",
                   bus_if.wen, bus_if.ren, bus_if.addr);
          e.len = 0;
        end else begin
          e = exp_bus.pop_front();
          check("bus_wen", 32'(bus_if.wen), 32'(e.wr));
          check("bus_ren", 32'(bus_if.ren), 32'(!e.wr));
          check("bus_addr", bus_if.addr, e.addr);
          check("bus_wmask", 32'(bus_if.wmask), 32'(e.wmask));
          if (e.wr) check("bus_wdata", bus_if.wdata, e.wdata);
        end
      end else if ((bus_if.wen || bus_if.ren) && active) begin
        len++;
      end else if (active) begin
        active = 1'b0;
        if (e.len != 0) check("bus_req_len", 32'(len), 32'(e.len));
      end
    end
  end

  // UART TX monitor: decode each byte at bit centres and score it
  initial begin : tx_mon
    logic [7:0] b;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0 && !rst) begin
        repeat (CPB / 2) @(negedge clk);
        check("tx_start_bit", 32'(uart_tx), 32'h0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        check("tx_stop_bit", 32'(uart_tx), 32'h1);
        if (exp_tx.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tx_byte: got %h, expected none", b);
        end else begin
          want = exp_tx.pop_front();
          check("tx_byte", 32'(b), 32'(want));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_addr(input logic [7:0] cmd, input logic [31:0] a);
    send_byte(cmd, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_addr(8'h57, a);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
  endtask

  task automatic expect_bus(input bit wr, input logic [31:0] a, input logic [31:0] d, input int len);
    bus_exp_t e;
    e.wr    = wr;
    e.addr  = a;
    e.wdata = d;
    e.wmask = wr ? 4'hF : 4'h0;
    e.len   = len;
    exp_bus.push_back(e);
  endtask

  task automatic wait_drained(input string name);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_bus.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_tx.size() + exp_bus.size()), 32'h0);
    repeat (3 * CPB) @(negedge clk);
  endtask

  initial begin : watchdog
    #600_000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    repeat (4) @(negedge clk);
    check("rst_uart_tx", 32'(uart_tx), 32'h1);
    check("rst_cpu_hold", 32'(cpu_hold), 32'h0);
    check("rst_wen", 32'(bus_if.wen), 32'h0);
    check("rst_ren", 32'(bus_if.ren), 32'h0);
    check("rst_addr", bus_if.addr, 32'h0);
    check("rst_wdata", bus_if.wdata, 32'h0);
    check("rst_wmask", 32'(bus_if.wmask), 32'h0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    // write frame
    expect_bus(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2);
    exp_tx.push_back(8'h06);
    send_write(32'h0000_0100, 32'hDEAD_BEEF);
    wait_drained("write_done");

    // read frame, preloaded data returned little-endian
    pre_idx = 8'h40;
    pre_val = 32'h1234_5678;
    pre_en  = 1'b1;
    @(negedge clk);
    pre_en  = 1'b0;
    expect_bus(1'b0, 32'h0000_0100, 32'h0, 2);
    exp_tx.push_back(8'h78);
    exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h12);
    send_addr(8'h52, 32'h0000_0100);
    wait_drained("read_done");

    // bus timeout: ren held exactly BUS_TIMEOUT cycles, NAK
    done_en = 1'b0;
    expect_bus(1'b0, 32'h0000_0200, 32'h0, BUS_TIMEOUT);
    exp_tx.push_back(8'h15);
    send_addr(8'h52, 32'h0000_0200);
    wait_drained("timeout_nak");
    done_en = 1'b1;
    expect_bus(1'b1, 32'h0000_0104, 32'hCAFE_F00D, 2);
    exp_tx.push_back(8'h06);
    send_write(32'h0000_0104, 32'hCAFE_F00D);
    wait_drained("write_after_timeout");

    // hold / go / ignored byte
    exp_tx.push_back(8'h06);
    send_byte(8'h48, 1'b1);
    wait_drained("hold_ack");
    check("cpu_hold_set", 32'(cpu_hold), 32'h1);
    exp_tx.push_back(8'h06);
    send_byte(8'h47, 1'b1);
    wait_drained("go_ack");
    check("cpu_hold_clr", 32'(cpu_hold), 32'h0);
    send_byte(8'h00, 1'b1);
    repeat (20 * CPB) @(negedge clk);

    // inter-byte gap drops a partial frame; unaligned address passes through
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (500) @(negedge clk);
    expect_bus(1'b1, 32'h0000_0182, 32'h0102_0304, 2);
    exp_tx.push_back(8'h06);
    send_write(32'h0000_0182, 32'h0102_0304);
    wait_drained("write_after_gap");

    // framing error on an 'H' byte, then a short glitch
    send_byte(8'h48, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    check("framing_no_hold", 32'(cpu_hold), 32'h0);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    exp_tx.push_back(8'h06);
    send_byte(8'h48, 1'b1);
    wait_drained("hold_after_glitch");
    check("cpu_hold_set2", 32'(cpu_hold), 32'h1);

    // reset while the bridge waits in BUS
    done_en = 1'b0;
    expect_bus(1'b1, 32'h0000_0300, 32'h55AA_55AA, 0);
    send_write(32'h0000_0300, 32'h55AA_55AA);
    n = 0;
    while (!bus_if.wen && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wen_before_rst", 32'(bus_if.wen), 32'h1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_wen", 32'(bus_if.wen), 32'h0);
    check("rst_mid_ren", 32'(bus_if.ren), 32'h0);
    check("rst_mid_uart_tx", 32'(uart_tx), 32'h1);
    check("rst_mid_cpu_hold", 32'(cpu_hold), 32'h0);
    check("rst_mid_addr", bus_if.addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    done_en = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    // bridge fully usable after reset
    expect_bus(1'b0, 32'h0000_0104, 32'h0, 2);
    exp_tx.push_back(8'h0D);
    exp_tx.push_back(8'hF0);
    exp_tx.push_back(8'hFE);
    exp_tx.push_back(8'hCA);
    send_addr(8'h52, 32'h0000_0104);
    wait_drained("read_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
